// File: rtl/plc_sequencer.sv
// Four-cycle fetch/load/read/exec sequencer for the PLC ALU datapath.
// It owns the program counter and a return-address stack, and drives the decoded operand fields.
module plc_sequencer #(
    parameter int WIDTH       = 8,
    parameter int IWIDTH      = 8,
    parameter int SOURCES     = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int PC_WIDTH    = 6,
    parameter int INSTR_WIDTH = 40,
    parameter int STACK_DEPTH = 4,
    localparam int CW         = $clog2(SOURCES)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   run_i,
    output logic [PC_WIDTH-1:0]    prog_addr_o,
    input  logic [INSTR_WIDTH-1:0] prog_data_i,
    input  logic                   zero_flag_i,
    output logic [IWIDTH-1:0]      op_code_o,
    output logic [ADDR_WIDTH-1:0]  source1_o,
    output logic [ADDR_WIDTH-1:0]  source2_o,
    output logic [CW-1:0]          source1_choice_o,
    output logic [CW-1:0]          source2_choice_o,
    output logic [ADDR_WIDTH-1:0]  destination_o,
    output logic [1:0]             dest_choice_o,
    output logic                   push_o,
    output logic                   pop_o,
    output logic [PC_WIDTH-1:0]    instr_addr_o,
    output logic                   halted_o,
    output logic                   fault_o
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int SIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int FB  = 3 * ADDR_WIDTH;

    localparam logic [IWIDTH-1:0] OP_JMP  = IWIDTH'(8'hF0);
    localparam logic [IWIDTH-1:0] OP_JZ   = IWIDTH'(8'hF1);
    localparam logic [IWIDTH-1:0] OP_JNZ  = IWIDTH'(8'hF2);
    localparam logic [IWIDTH-1:0] OP_CALL = IWIDTH'(8'hF3);
    localparam logic [IWIDTH-1:0] OP_RET  = IWIDTH'(8'hF4);
    localparam logic [IWIDTH-1:0] OP_HALT = IWIDTH'(8'hFF);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_LOAD  = 3'd1,
        S_READ  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    function automatic logic is_ctrl(input logic [IWIDTH-1:0] op);
        case (op)
            OP_JMP, OP_JZ, OP_JNZ, OP_CALL, OP_RET, OP_HALT: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    state_t                  state_q;
    logic [PC_WIDTH-1:0]     pc_q;
    logic [PC_WIDTH-1:0]     prog_addr_q;
    logic [PC_WIDTH-1:0]     instr_addr_q;
    logic [IWIDTH-1:0]       ir_op_q;
    logic [1:0]              ir_dc_q;
    logic [PC_WIDTH-1:0]     ir_tgt_q;
    logic [IWIDTH-1:0]       op_code_q;
    logic [ADDR_WIDTH-1:0]   src1_q;
    logic [ADDR_WIDTH-1:0]   src2_q;
    logic [ADDR_WIDTH-1:0]   dest_q;
    logic [CW-1:0]           s1c_q;
    logic [CW-1:0]           s2c_q;
    logic [1:0]              dc_q;
    logic                    push_q;
    logic                    pop_q;
    logic                    halted_q;
    logic                    fault_q;
    logic [PC_WIDTH-1:0]     stack_q [STACK_DEPTH];
    logic [SPW-1:0]          sp_q;

    logic [PC_WIDTH-1:0]     pc_inc;
    logic [PC_WIDTH-1:0]     pc_d;
    logic                    stack_err_d;
    logic                    halt_d;
    logic                    stk_full;
    logic                    stk_empty;
    logic [SIW-1:0]          top_idx;
    logic                    unused_bits;

    // Reserved instruction bits and the datapath width do not affect sequencing.
    assign unused_bits = ^{prog_data_i[FB+1 -: 2], (WIDTH > 0)};

    // Resolve the program counter that follows the instruction currently in EXEC.
    always_comb begin
        pc_inc      = pc_q + PC_WIDTH'(1);
        stk_full    = (sp_q == SPW'(STACK_DEPTH));
        stk_empty   = (sp_q == SPW'(0));
        top_idx     = SIW'(sp_q - SPW'(1));
        pc_d        = pc_inc;
        stack_err_d = 1'b0;
        halt_d      = 1'b0;
        case (ir_op_q)
            OP_JMP:  pc_d = ir_tgt_q;
            OP_JZ:   pc_d = zero_flag_i ? ir_tgt_q : pc_inc;
            OP_JNZ:  pc_d = zero_flag_i ? pc_inc : ir_tgt_q;
            OP_CALL: begin
                if (stk_full) begin
                    stack_err_d = 1'b1;
                    pc_d        = pc_q;
                end else begin
                    pc_d        = ir_tgt_q;
                end
            end
            OP_RET: begin
                if (stk_empty) begin
                    stack_err_d = 1'b1;
                    pc_d        = pc_q;
                end else begin
                    pc_d        = stack_q[top_idx];
                end
            end
            OP_HALT: begin
                halt_d = 1'b1;
                pc_d   = pc_q;
            end
            default: pc_d = pc_inc;
        endcase
    end

    // Sequencer state machine with registered datapath-facing outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            prog_addr_q  <= '0;
            instr_addr_q <= '0;
            ir_op_q      <= '0;
            ir_dc_q      <= 2'b11;
            ir_tgt_q     <= '0;
            op_code_q    <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            dest_q       <= '0;
            s1c_q        <= '0;
            s2c_q        <= '0;
            dc_q         <= 2'b11;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            sp_q         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    prog_addr_q <= pc_q;
                    state_q     <= run_i ? S_LOAD : S_FETCH;
                end
                S_LOAD: begin
                    // Fields go out now so they are stable for the whole READ cycle.
                    ir_op_q   <= prog_data_i[INSTR_WIDTH-1 -: IWIDTH];
                    ir_dc_q   <= prog_data_i[FB+2 +: 2];
                    ir_tgt_q  <= prog_data_i[PC_WIDTH-1:0];
                    op_code_q <= is_ctrl(prog_data_i[INSTR_WIDTH-1 -: IWIDTH]) ?
                                 IWIDTH'(0) : prog_data_i[INSTR_WIDTH-1 -: IWIDTH];
                    s1c_q     <= prog_data_i[FB+6 +: CW];
                    s2c_q     <= prog_data_i[FB+4 +: CW];
                    src1_q    <= prog_data_i[2*ADDR_WIDTH +: ADDR_WIDTH];
                    src2_q    <= prog_data_i[ADDR_WIDTH +: ADDR_WIDTH];
                    dest_q    <= prog_data_i[0 +: ADDR_WIDTH];
                    dc_q      <= 2'b11;
                    state_q   <= S_READ;
                end
                S_READ: begin
                    dc_q <= is_ctrl(ir_op_q) ? 2'b11 : ir_dc_q;
                    if ((ir_op_q == OP_CALL) && !stk_full) begin
                        push_q       <= 1'b1;
                        instr_addr_q <= pc_inc;
                    end else begin
                        push_q       <= 1'b0;
                    end
                    pop_q   <= (ir_op_q == OP_RET) && !stk_empty;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    push_q <= 1'b0;
                    pop_q  <= 1'b0;
                    dc_q   <= 2'b11;
                    if (stack_err_d || halt_d) begin
                        state_q   <= S_HALT;
                        halted_q  <= 1'b1;
                        fault_q   <= stack_err_d;
                        op_code_q <= '0;
                        src1_q    <= '0;
                        src2_q    <= '0;
                        dest_q    <= '0;
                        s1c_q     <= '0;
                        s2c_q     <= '0;
                    end else begin
                        state_q     <= S_FETCH;
                        pc_q        <= pc_d;
                        prog_addr_q <= pc_d;
                        if (ir_op_q == OP_CALL) begin
                            stack_q[sp_q[SIW-1:0]] <= pc_inc;
                            sp_q                   <= sp_q + SPW'(1);
                        end else if (ir_op_q == OP_RET) begin
                            sp_q <= sp_q - SPW'(1);
                        end else begin
                            sp_q <= sp_q;
                        end
                    end
                end
                S_HALT: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                    dc_q     <= 2'b11;
                    push_q   <= 1'b0;
                    pop_q    <= 1'b0;
                end
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign prog_addr_o      = prog_addr_q;
    assign op_code_o        = op_code_q;
    assign source1_o        = src1_q;
    assign source2_o        = src2_q;
    assign source1_choice_o = s1c_q;
    assign source2_choice_o = s2c_q;
    assign destination_o    = dest_q;
    // A write must never escape in a cycle where reset is being applied.
    assign dest_choice_o    = rst_i ? 2'b11 : dc_q;
    assign push_o           = push_q;
    assign pop_o            = pop_q;
    assign instr_addr_o     = instr_addr_q;
    assign halted_o         = halted_q;
    assign fault_o          = fault_q;

endmodule

// File: doc/plc_sequencer.md
Name: plc_sequencer

Overview:
- Fetch/decode/sequence unit that drives the decoded-instruction side of the ALU datapath module: op_code, source/destination addresses and choices, push/pop and instr_addr.
- Reads instruction words from a synchronous program ROM.
- Takes zero_flag back from the datapath for conditional branches.
- Keeps its own return-address stack for CALL/RET and mirrors each stack action to the datapath as a push/pop pulse.

Parameters:
- WIDTH, 8, datapath word width
- IWIDTH, 8, op_code width
- SOURCES, 4, operand source count; choice width = $clog2(SOURCES)
- ADDR_WIDTH, 8, operand/destination address width
- PC_WIDTH, 6, program counter width
- INSTR_WIDTH, 40, program word width; must equal IWIDTH+8+3*ADDR_WIDTH
- STACK_DEPTH, 4, return-address stack entries

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- run  in  1  level enable, sampled in FETCH
- prog_addr  out  PC_WIDTH  ROM address
- prog_data  in  INSTR_WIDTH  ROM data, valid one cycle after prog_addr
- zero_flag  in  1  datapath Z flag
- op_code  out  IWIDTH  ALU opcode
- source1, source2  out  ADDR_WIDTH  operand fields
- source1_choice, source2_choice  out  $clog2(SOURCES)  operand selects
- destination  out  ADDR_WIDTH  destination field
- dest_choice  out  2  00 rf, 01 bit RAM, 10 word RAM, 11 no write
- push, pop  out  1  single-cycle stack pulses to datapath
- instr_addr  out  PC_WIDTH  return address accompanying push
- halted  out  1  sticky halt
- fault  out  1  sticky stack error

Behaviour:
- Instruction word layout, MSB first:
  - op_code[39:32]
  - src1_choice[31:30]
  - src2_choice[29:28]
  - dest_choice[27:26]
  - reserved[25:24], ignored
  - source1[23:16]
  - source2[15:8]
  - destination[7:0]
- Reset values: pc=0, state FETCH, prog_addr=0, op_code/sources/choices/destination=0, dest_choice=2'b11, push=pop=0, instr_addr=0, halted=0, fault=0, stack pointer=0.
- States: FETCH -> LOAD -> READ -> EXEC -> FETCH, plus HALT. Four cycles per instruction.
- FETCH:
  - prog_addr=pc.
  - If run=0, stay in FETCH; otherwise go to LOAD.
- LOAD: latch prog_data into the instruction register.
- READ:
  - Drive all fields to the outputs with dest_choice forced to 11.
  - This gives the synchronous RAM/regfile reads one cycle.
- EXEC:
  - Fields held; dest_choice = instruction value for ALU ops.
  - The datapath writes at the end of EXEC; dest_choice is 11 in every other state.
- Control opcodes (never forwarded to the datapath):
  - While a control opcode is in READ/EXEC: op_code output = 8'h00 and dest_choice = 11.
  - JMP 8'hF0: pc <= destination[PC_WIDTH-1:0].
  - JZ 8'hF1: jump if zero_flag=1 in EXEC, else pc+1.
  - JNZ 8'hF2: jump if zero_flag=0 in EXEC, else pc+1.
  - CALL 8'hF3: push pc+1 onto the stack, pulse push for one cycle with instr_addr=pc+1, then jump.
  - RET 8'hF4: pc <= top of stack, pulse pop for one cycle.
  - HALT 8'hFF: enter HALT.
- All other opcodes advance pc <= pc+1 in EXEC. pc wraps modulo 2^PC_WIDTH (63 -> 0).
- zero_flag is sampled in EXEC only. It reflects the flag register after the previous instruction's EXEC.
- Stack errors:
  - CALL with the stack full, or RET with it empty: no push/pop pulse, pc unchanged.
  - fault=1, halted=1, enter HALT.
- HALT:
  - halted=1; all outputs at idle values (dest_choice=11, push=pop=0).
  - Only rst exits HALT.
- Reset mid-operation:
  - dest_choice is combinationally forced to 11 while rst=1, so an EXEC cycle coincident with reset performs no write.
  - Everything else returns to reset values on the edge; there is no partial-instruction replay.
- run deassertion never aborts an in-flight instruction; it is honoured at the next FETCH.

Test Plan:
- Reset, run=1, ROM[0] = ALU op 8'h01 with dest_choice 00 and destination 3 -> prog_addr=0 in cycle 0; dest_choice=00, destination=3 in cycle 3 only; dest_choice=11 in cycles 0-2; prog_addr=1 in cycle 4.
- ROM[5]=JZ to 20: with zero_flag=1 -> next fetch addr 20; with zero_flag=0 -> next fetch addr 6; op_code=0 and dest_choice=11 throughout both.
- CALL 10 at pc 2, then RET at ROM[10] -> push=1 and instr_addr=3 for one cycle; next fetch 10; RET gives pop=1 for one cycle; next fetch 3.
- Five nested CALLs with STACK_DEPTH=4 -> fifth gives fault=1 and halted=1 with no push pulse; RET at reset (empty stack) -> fault=1.
- Sequential ALU ops at pc 63 -> next prog_addr=0. HALT at pc 7 -> halted stays 1 for 100 cycles with run=1, prog_addr frozen.
- rst asserted during EXEC of a dest_choice=10 op -> dest_choice=11 that cycle; next cycle pc=0, state FETCH. run=0 held for 10 cycles -> prog_addr stable and no EXEC.
